// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the snooping-bus slot arbiter:
// command codes, bus ids, field widths and slot timing.
package bus_arbiter_pkg;

   typedef enum logic [2:0] {
      CMD_NOP     = 3'd0,
      CMD_BUSRD   = 3'd1,
      CMD_BUSRDX  = 3'd2,
      CMD_BUSUPGR = 3'd3,
      CMD_FLUSH   = 3'd4
   } cmd_e;

   typedef enum logic [1:0] {
      BUSID_L2_0 = 2'd0,
      BUSID_L2_1 = 2'd1,
      BUSID_L2_2 = 2'd2,
      BUSID_MEM  = 2'd3
   } busid_e;

   localparam int CMD_W    = 3;
   localparam int TAG_W    = 5;
   localparam int ADDR_W   = 26;
   localparam int DATA_W   = 64;
   localparam int CYC_W    = 3;
   localparam int SLOT_LEN = 8;

   localparam logic [CYC_W-1:0] LAST_BEAT = CYC_W'(SLOT_LEN - 1);

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/snooper side of the shared bus plus the arbitrated bus outputs.
// master: arbiter (drives grant and bus_*); slave: requesters and snoopers.
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int NSNOOP = 4
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        req;
   logic [CMD_W*NREQ-1:0]  req_cmd;
   logic [TAG_W*NREQ-1:0]  req_tag;
   logic [ADDR_W*NREQ-1:0] req_addr;
   logic [DATA_W*NREQ-1:0] req_data;
   logic [NREQ-1:0]        grant;
   logic [NSNOOP-1:0]      snoop_nack;
   logic                   bus_valid;
   logic [CMD_W-1:0]       bus_cmd;
   logic [TAG_W-1:0]       bus_tag;
   logic [ADDR_W-1:0]      bus_addr;
   logic [DATA_W-1:0]      bus_data;
   logic                   bus_nack;
   logic [CYC_W-1:0]       bus_cycle;
   logic [OW-1:0]          bus_owner;

   modport master (
      input  req, req_cmd, req_tag, req_addr, req_data, snoop_nack,
      output grant, bus_valid, bus_cmd, bus_tag, bus_addr, bus_data,
      output bus_nack, bus_cycle, bus_owner
   );

   modport slave (
      output req, req_cmd, req_tag, req_addr, req_data, snoop_nack,
      input  grant, bus_valid, bus_cmd, bus_tag, bus_addr, bus_data,
      input  bus_nack, bus_cycle, bus_owner
   );

endinterface

// File: rtl/bus_arbiter_rr.sv
// Combinational round-robin picker: first set req bit from ptr upward, mod N.
// Ports: req, ptr in; one-hot gnt and binary gnt_idx out (0 when no req).
module bus_arbiter_rr #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic found;
   int   j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Slot-based round-robin arbiter and AND-OR mux for the snooping bus.
// Ports: clk, rst (async, active-low), bus (master modport of bus_arbiter_if).
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int NSNOOP = 4
) (
   input  logic           clk,
   input  logic           rst,
   bus_arbiter_if.master  bus
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [CYC_W-1:0] cycle_r;
   logic             owner_valid_r;
   logic [OW-1:0]    owner_r;
   logic [OW-1:0]    rr_ptr_r;

   logic [NREQ-1:0]  rr_gnt;
   logic [OW-1:0]    rr_idx;
   logic [OW-1:0]    ptr_next;
   logic             last_beat;
   logic             any_req;

   logic [CMD_W-1:0]  cmd;
   logic [TAG_W-1:0]  tag;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;

   assign last_beat = (cycle_r == LAST_BEAT);
   assign any_req   = |bus.req;
   assign ptr_next  = (rr_idx == OW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;

   bus_arbiter_rr #(.N(NREQ), .IW(OW)) u_rr (
      .req     (bus.req),
      .ptr     (rr_ptr_r),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // Slot counter wraps naturally at 8; ownership changes only at beat 7.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_r       <= '0;
         owner_valid_r <= 1'b0;
         owner_r       <= '0;
         rr_ptr_r      <= '0;
      end else begin
         cycle_r <= cycle_r + 1'b1;
         if (last_beat) begin
            owner_valid_r <= any_req;
            if (any_req) begin
               owner_r  <= rr_idx;
               rr_ptr_r <= ptr_next;
            end
         end
      end
   end

   always_comb begin
      cmd  = CMD_NOP;
      tag  = '0;
      addr = '0;
      data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_valid_r && (owner_r == OW'(i))) begin
            cmd  = cmd  | bus.req_cmd[CMD_W*i +: CMD_W];
            tag  = tag  | bus.req_tag[TAG_W*i +: TAG_W];
            addr = addr | bus.req_addr[ADDR_W*i +: ADDR_W];
            data = data | bus.req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   assign bus.grant     = last_beat ? rr_gnt : '0;
   assign bus.bus_valid = owner_valid_r;
   assign bus.bus_cmd   = cmd;
   assign bus.bus_tag   = tag;
   assign bus.bus_addr  = addr;
   assign bus.bus_data  = data;
   assign bus.bus_nack  = (|bus.snoop_nack) & owner_valid_r;
   assign bus.bus_cycle = cycle_r;
   assign bus.bus_owner = owner_valid_r ? owner_r : '0;

endmodule
